// File: rtl/multi_booth_acc.sv
// Accumulates a frame of multiplier products and hands the sum downstream over valid/ready.
// Optional MULACC_SAT_EN: clamp the accumulator on carry-out instead of wrapping.
module multi_booth_acc #(
  parameter int unsigned P_W   = 16,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic [P_W-1:0]   i_p,
  input  logic             i_rdy,
  output logic             o_mul_clr,
  output logic             o_busy,
  output logic [ACC_W-1:0] o_acc_data,
  output logic             o_acc_valid,
  input  logic             i_acc_ready,
  output logic             o_ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NEXT = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   r_len_q;
  logic [CNT_W-1:0]   w_len_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic               r_rdy_q;
  logic               r_mul_clr;
  logic               r_busy;
  logic               r_acc_valid;
  logic               w_event;
  logic               w_last;
  logic [SUM_W-1:0]   w_sum;

  // Rising edge of the multiplier's done level marks a new product.
  assign w_event = i_rdy & ~r_rdy_q;
  assign w_last  = (r_cnt == (r_len_q - CNT_W'(1)));
  assign w_sum   = SUM_W'(r_acc) + SUM_W'(i_p);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len_q;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_len_nxt   = i_len;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_NEXT;
        end
      end
      S_NEXT: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_event) begin
          if (w_sum[ACC_W]) begin
            w_ovf_nxt = 1'b1;
`ifdef MULACC_SAT_EN
            w_acc_nxt = {ACC_W{1'b1}};
`else
            w_acc_nxt = w_sum[ACC_W-1:0];
`endif
          end else begin
            w_acc_nxt = w_sum[ACC_W-1:0];
          end
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = w_last ? S_DONE : S_NEXT;
        end
      end
      S_DONE: begin
        if (i_acc_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Flag outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len_q     <= '0;
      r_ovf       <= 1'b0;
      r_rdy_q     <= 1'b0;
      r_mul_clr   <= 1'b0;
      r_busy      <= 1'b0;
      r_acc_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len_q     <= w_len_nxt;
      r_ovf       <= w_ovf_nxt;
      r_rdy_q     <= i_rdy;
      r_mul_clr   <= (w_state_nxt == S_NEXT);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_acc_valid <= (w_state_nxt == S_DONE);
    end
  end

  assign o_mul_clr   = r_mul_clr;
  assign o_busy      = r_busy;
  assign o_acc_data  = r_acc;
  assign o_acc_valid = r_acc_valid;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_multi_booth_acc.sv
// Directed self-checking bench for multi_booth_acc (default widths plus an ACC_W=17 instance).
module tb_multi_booth_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  len;
  logic [15:0] p;
  logic        rdy;
  logic        acc_ready;

  logic        mul_clr, busy, acc_valid, ovf;
  logic [23:0] acc_data;
  logic        mul_clr17, busy17, acc_valid17, ovf17;
  logic [16:0] acc_data17;

  int n_checks = 0;
  int n_fail   = 0;
  int n_clr    = 0;
  int clr_base;
  logic [23:0] exp_acc;

  always #5 clk = ~clk;

  multi_booth_acc u_dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_len(len), .i_p(p), .i_rdy(rdy),
    .o_mul_clr(mul_clr), .o_busy(busy), .o_acc_data(acc_data), .o_acc_valid(acc_valid),
    .i_acc_ready(acc_ready), .o_ovf(ovf)
  );

  multi_booth_acc #(.ACC_W(17)) u_dut17 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_len(len), .i_p(p), .i_rdy(rdy),
    .o_mul_clr(mul_clr17), .o_busy(busy17), .o_acc_data(acc_data17), .o_acc_valid(acc_valid17),
    .i_acc_ready(acc_ready), .o_ovf(ovf17)
  );

  always @(negedge clk) if (mul_clr) n_clr++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Emulates the multiplier: wait for the clear pulse, then raise rdy with a product.
  task automatic feed(input logic [15:0] val);
    int k;
    k = 0;
    while (mul_clr !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    if (mul_clr !== 1'b1) check("mul_clr_timeout", 32'(mul_clr), 32'd1);
    tick();
    p   = val;
    rdy = 1'b1;
    tick();
    exp_acc = exp_acc + 24'(val);
    check("acc_after_event", 32'(acc_data), 32'(exp_acc));
    rdy = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; len = 4'd3; p = '0; rdy = 1'b0; acc_ready = 1'b0;
    exp_acc = '0;

    // Reset held with start asserted
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mul_clr", 32'(mul_clr), 32'd0);
    check("rst_valid", 32'(acc_valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_acc", 32'(acc_data), 32'd0);
    reset = 1'b1; start = 1'b0;
    tick(); tick();
    check("idle_busy", 32'(busy), 32'd0);

    // len=3 basic frame
    clr_base = n_clr;
    len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_mul_clr", 32'(mul_clr), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    exp_acc = '0;
    feed(16'h1234);
    feed(16'h0100);
    feed(16'hFFFF);
    check("f3_valid", 32'(acc_valid), 32'd1);
    check("f3_acc", 32'(acc_data), 32'h011333);
    check("f3_ovf", 32'(ovf), 32'd0);
    check("f3_clr_pulses", 32'(n_clr - clr_base), 32'd3);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check("f3_valid_drop", 32'(acc_valid), 32'd0);
    check("f3_busy_drop", 32'(busy), 32'd0);

    // Overflow frame: 3 x 0xFFFF
    len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    exp_acc = '0;
    feed(16'hFFFF);
    feed(16'hFFFF);
    feed(16'hFFFF);
    check("ov_valid17", 32'(acc_valid17), 32'd1);
    check("ov_ovf17", 32'(ovf17), 32'd1);
`ifdef MULACC_SAT_EN
    check("ov_acc17", 32'(acc_data17), 32'h1FFFF);
`else
    check("ov_acc17", 32'(acc_data17), 32'h0FFFD);
`endif
    check("ov_acc24", 32'(acc_data), 32'h02FFFD);
    check("ov_ovf24", 32'(ovf), 32'd0);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;

    // len=0 means 16 products
    len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    exp_acc = '0;
    for (int i = 0; i < 15; i++) feed(16'h0001);
    check("l0_not_done_15", 32'(acc_valid), 32'd0);
    feed(16'h0001);
    check("l0_valid_16", 32'(acc_valid), 32'd1);
    check("l0_acc", 32'(acc_data), 32'h000010);

    // Held in DONE: start and a rdy rise must be ignored
    for (int i = 0; i < 5; i++) begin
      start = (i == 0);
      rdy   = (i == 2);
      p     = 16'h00AA;
      tick();
      check("hold_acc", 32'(acc_data), 32'h000010);
      check("hold_valid", 32'(acc_valid), 32'd1);
    end
    start = 1'b1; rdy = 1'b0; acc_ready = 1'b1;
    tick();
    start = 1'b0; acc_ready = 1'b0;
    check("acc6_valid", 32'(acc_valid), 32'd0);
    check("acc6_busy", 32'(busy), 32'd0);
    tick();
    check("acc6_start_ignored", 32'(busy), 32'd0);

    // rdy already high at frame start, then reset mid-frame
    rdy = 1'b1; len = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    p = 16'h0005;
    for (int i = 0; i < 4; i++) tick();
    check("stale_rdy_acc", 32'(acc_data), 32'd0);
    check("stale_rdy_busy", 32'(busy), 32'd1);
    check("stale_rdy_clr", 32'(mul_clr), 32'd0);
    rdy = 1'b0;
    tick();
    rdy = 1'b1;
    tick();
    check("fresh_rdy_acc", 32'(acc_data), 32'h5);
    check("fresh_rdy_clr", 32'(mul_clr), 32'd1);
    rdy = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_acc", 32'(acc_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    tick(); tick();
    check("mid_rst_valid", 32'(acc_valid), 32'd0);
    check("mid_rst_busy2", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_booth_acc.md
# multi_booth_acc

Downstream accumulation stage for the sequential 8-bit shift-add multiplier.
- Watches the multiplier's `p`/`rdy` outputs and detects each product completion.
- Sums a frame of `len` products into a wide accumulator, then hands the total downstream over a valid/ready handshake.
- Drives a one-cycle clear pulse that re-arms the multiplier for the next product, so the multiplier plus this block form a multiply-accumulate datapath.

## Interface
- `P_W`, default 16, product width; must equal the multiplier's `p` width.
- `ACC_W`, default 24, accumulator width; `ACC_W >= P_W` is required.
- `CNT_W`, default 4, frame-length counter width.
- `clk`, in, 1, single clock; all logic is on the rising edge.
- `reset`, in, 1, synchronous, active-low. Low at a rising edge resets the block.
- `start`, in, 1, frame request; honoured only in IDLE.
- `len`, in, CNT_W, products per frame, sampled with `start`; 0 means 2^CNT_W.
- `p`, in, P_W, multiplier product, treated as unsigned.
- `rdy`, in, 1, multiplier done level; stays high until the multiplier is cleared.
- `mul_clr`, out, 1, one-cycle pulse that restarts the multiplier.
- `busy`, out, 1, high when state is not IDLE.
- `acc_data`, out, ACC_W, frame sum; valid while `acc_valid`=1.
- `acc_valid`, out, 1, result-available flag.
- `acc_ready`, in, 1, downstream accept.
- `ovf`, out, 1, accumulator overflowed in the current frame.

## Operation
- States: IDLE, NEXT, WAIT, DONE.
- IDLE, on `start`=1:
  - latch `len` into `len_q`;
  - clear the accumulator, `ovf` and the product count;
  - go to NEXT.
- NEXT: `mul_clr`=1 for exactly this cycle, then go to WAIT.
- Edge detection: `rdy_q` registers `rdy` every cycle in every state. A product event is `rdy`=1 and `rdy_q`=0.
- WAIT, on a product event:
  - acc <= acc + zero-extended `p`;
  - cnt <= cnt + 1;
  - if cnt == `len_q`-1 (modulo 2^CNT_W), go to DONE; otherwise go to NEXT.
- DONE: `acc_valid`=1 and `acc_data` is held stable. When `acc_ready`=1, go to IDLE and clear `acc_valid` on the next edge.
- Overflow:
  - A carry out of ACC_W bits sets `ovf`.
  - `ovf` stays set until the next accepted `start`.
  - Without saturation, the sum wraps modulo 2^ACC_W.
- Boundary cases:
  - `start` while not IDLE is ignored.
  - `start` and `acc_ready` in the same DONE cycle: `start` is ignored, because the block is not in IDLE that cycle.
  - A product event outside WAIT is ignored, but `rdy_q` still tracks `rdy`.
  - `rdy` already high on entry to WAIT (`rdy_q`=1) is not an event; the block waits for a fresh rising edge.
  - `acc_ready` outside DONE has no effect.
- Reset values: state IDLE; `mul_clr`, `busy`, `acc_valid` and `ovf` all 0; `acc_data` 0; count 0; `rdy_q` 0.
- Reset mid-frame aborts the frame with no output.

## Timing
- `start` sampled at edge t0: NEXT in t1 with `mul_clr`=1 and `busy`=1. WAIT begins at t2.
- Product event sampled at edge te:
  - updated `acc_data` is visible in cycle te+1;
  - on the last product, `acc_valid`=1 in cycle te+1;
  - on other products, `mul_clr`=1 in cycle te+1.
- Minimum spacing between accepted products is 2 cycles, set by the NEXT state and the edge detect.
- `acc_valid` falls in the cycle after `acc_ready` is sampled high. `busy` falls in the same cycle.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- `MULACC_SAT_EN` defined: on carry out, the accumulator clamps to 2^ACC_W-1 and holds there for the rest of the frame; `ovf` is set.
- `MULACC_SAT_EN` undefined: the accumulator wraps modulo 2^ACC_W; `ovf` is set.

## Test plan
- Reset held low for 2 cycles with `start`=1 -> all outputs 0, state IDLE; after release, `busy` is 0 until a new `start`.
- `len`=3, products 0x1234, 0x0100, 0xFFFF, each presented as a `rdy` rise -> `mul_clr` pulses 3 times; `acc_data`=0x011333; `acc_valid`=1 one cycle after the third event; `ovf`=0.
- `ACC_W`=17, `len`=3, product 0xFFFF three times -> `ovf`=1. Without `MULACC_SAT_EN`, `acc_data`=0x0FFFD; with it, `acc_data`=0x1FFFF.
- `len`=0, product 0x0001 sixteen times -> `acc_data`=0x000010; exactly 16 events are consumed.
- `acc_ready` held low for 5 cycles in DONE with `start` pulsed and a `rdy` rise injected -> `acc_data` stable and `start` ignored; acceptance on cycle 6 returns to IDLE with `acc_valid`=0 next cycle.
- `rdy` held high at frame start, and `reset` low in WAIT after 1 of 2 products -> no event until `rdy` toggles low then high; the reset clears the accumulator and `busy`, and no `acc_valid` is produced.
